// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parameterised SPI slave, word-wise receive and transmit
//
// Purpose:
//   SPI slave clocked only by SCLK. It receives WIDTH-bit words on MOSI
//   and presents each completed word on rx_data, inverting rx_toggle once
//   per word. In parallel it shifts tx_data out on MISO. Any number of
//   back-to-back words may be sent within one CS-low frame.
//
// Parameters:
//   WIDTH     word length in bits, 2..32
//   CPOL      SCLK idle level (0: leading edge rising, 1: leading edge falling)
//   CPHA      0: sample on leading edge and launch on trailing edge
//             1: launch on leading edge and sample on trailing edge
//   LSB_FIRST 1: bit 0 is first on the wire, 0: bit WIDTH-1 is first
//
// Ports:
//   SCLK      in   serial clock from the master (only clock of the block)
//   reset     in   asynchronous, active-high reset
//   CS        in   active-low chip select; high clears the frame asynchronously
//   MOSI      in   serial data from the master
//   MISO      out  serial data to the master; high-Z while CS=1 or reset=1
//   tx_data   in   word to transmit, captured at the first sample edge of a word
//   rx_data   out  last fully received word
//   rx_toggle out  inverts once per completed word (consumer-side CDC)
//   frame_err out  sticky flag: CS was raised mid-word (only with the macro)
//
// Build option:
//   SPI_SLAVE_PARAM_FRAME_ERR_EN  when defined, adds the frame_err output.

module spi_slave_param #(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 1
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_toggle
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);

    localparam int            CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    // Index of the bit that goes on the wire first.
    localparam int            FIRST = (LSB_FIRST != 0) ? 0 : WIDTH - 1;

    // Sample edge is the rising edge of samp_clk; launch edge is its falling
    // edge. Sampling happens on SCLK rising exactly when CPOL == CPHA.
    logic samp_clk;
    assign samp_clk = (CPOL == CPHA) ? SCLK : ~SCLK;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-2:0] rx_hold;   // bits of the current word received so far
    logic [WIDTH-1:0] rx_next;   // assembled word including the current MOSI bit
    logic [WIDTH-1:0] tx_load;   // tx word captured at the first sample edge
    logic [WIDTH-1:0] tx_shift;  // tx word after launch-edge shifts
    logic             tx_live;   // tx_shift holds the current word
    logic [WIDTH-1:0] tx_src;    // effective tx shift register contents
    logic [WIDTH-1:0] tx_next;
    logic             miso_bit;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    always_comb begin
        rx_next = '0;
        if (LSB_FIRST != 0) begin
            rx_next = {MOSI, rx_hold};
        end else begin
            rx_next = {rx_hold, MOSI};
        end
    end

    // Bit counter and partial word: cleared by reset and by CS high, so an
    // aborted word is simply discarded.
    always_ff @(posedge samp_clk or posedge reset or posedge CS) begin
        if (reset || CS) begin
            bit_cnt <= '0;
            rx_hold <= '0;
        end else begin
            if (LSB_FIRST != 0) begin
                rx_hold <= rx_next[WIDTH-1:1];
            end else begin
                rx_hold <= rx_next[WIDTH-2:0];
            end
            if (bit_cnt == LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Completed word and tx capture: only reset clears these, CS does not.
    always_ff @(posedge samp_clk or posedge reset) begin
        if (reset) begin
            rx_data   <= '0;
            rx_toggle <= 1'b0;
            tx_load   <= '0;
        end else if (!CS) begin
            if (bit_cnt == LAST) begin
                rx_data   <= rx_next;
                rx_toggle <= ~rx_toggle;
            end
            if (bit_cnt == '0) begin
                tx_load <= tx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    // The tx word is captured on the sample edge but shifted on the launch
    // edge. Rather than writing one register from both edges, the capture
    // lives in tx_load (sample domain) and the shifting copy in tx_shift
    // (launch domain). Until the first shift of a word, tx_live is low and
    // tx_load is the effective register; afterwards tx_shift is.
    always_comb begin
        tx_src  = tx_live ? tx_shift : tx_load;
        tx_next = '0;
        if (LSB_FIRST != 0) begin
            tx_next = {1'b0, tx_src[WIDTH-1:1]};
        end else begin
            tx_next = {tx_src[WIDTH-2:0], 1'b0};
        end
    end

    // Launch edge with bit_cnt=0 holds (the next word is not captured yet).
    always_ff @(negedge samp_clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
        end else if (!CS && (bit_cnt != '0)) begin
            tx_shift <= tx_next;
        end
    end

    always_ff @(negedge samp_clk or posedge reset or posedge CS) begin
        if (reset || CS) begin
            tx_live <= 1'b0;
        end else begin
            tx_live <= (bit_cnt != '0);
        end
    end

    // At a word boundary the first bit comes straight from tx_data so that
    // it is already valid before the first sample edge, even with CPHA=0.
    always_comb begin
        if (!CS && (bit_cnt == '0)) begin
            miso_bit = tx_data[FIRST];
        end else begin
            miso_bit = tx_src[FIRST];
        end
    end

    assign MISO = (CS || reset) ? 1'bz : miso_bit;

    // ------------------------------------------------------------------
    // Optional frame error flag
    // ------------------------------------------------------------------
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
    // bit_cnt is read here before its own CS-driven clear takes effect, so
    // this sees the count at the moment CS rose. A CS rise right after the
    // last sample edge sees bit_cnt already wrapped to 0 and raises nothing.
    always_ff @(posedge CS or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else if (bit_cnt != '0) begin
            frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - scoreboard bench for spi_slave_param
module tb_spi_slave_param;

    logic        reset;
    logic        cs_a, sclk_a, mosi_a;
    logic [7:0]  tx_a;
    wire         miso_a;
    wire  [7:0]  rx_a;
    wire         tog_a;
    logic        cs_b, sclk_b, mosi_b;
    logic [15:0] tx_b;
    wire         miso_b;
    wire  [15:0] rx_b;
    wire         tog_b;

    // A released MISO reads as 1; every Z check is arranged so that the
    // value the slave would otherwise drive is 0.
    pullup pu_a (miso_a);
    pullup pu_b (miso_b);

`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
    wire ferr_a, ferr_b;
`endif

    spi_slave_param dut_a (
        .SCLK(sclk_a), .reset(reset), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a),
        .tx_data(tx_a), .rx_data(rx_a), .rx_toggle(tog_a)
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        , .frame_err(ferr_a)
`endif
    );

    spi_slave_param #(.WIDTH(16), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) dut_b (
        .SCLK(sclk_b), .reset(reset), .CS(cs_b), .MOSI(mosi_b), .MISO(miso_b),
        .tx_data(tx_b), .rx_data(rx_b), .rx_toggle(tog_b)
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        , .frame_err(ferr_b)
`endif
    );

    int errors = 0;
    int checks = 0;
    int tog_cnt_a = 0;
    int tog_cnt_b = 0;
    logic [7:0]  exp_q_a[$];
    logic [15:0] exp_q_b[$];
    logic [7:0]  m8;
    logic [15:0] m16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: every rx_toggle change outside reset is a word.
    initial begin
        forever begin
            @(tog_a);
            if (!reset) begin
                #1;
                tog_cnt_a++;
                if (exp_q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_a_unexpected: actual=%0h required=none", rx_a);
                end else begin
                    check("rx_a_word", 32'(rx_a), 32'(exp_q_a.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(tog_b);
            if (!reset) begin
                #1;
                tog_cnt_b++;
                if (exp_q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_b_unexpected: actual=%0h required=none", rx_b);
                end else begin
                    check("rx_b_word", 32'(rx_b), 32'(exp_q_b.pop_front()));
                end
            end
        end
    end

    // Mode 0, LSB first, 8 bits. Master samples MISO just before the rising edge.
    task automatic word_a(input logic [7:0] tx, input logic [7:0] mo, output logic [7:0] mi);
        tx_a = tx;
        exp_q_a.push_back(mo);
        for (int i = 0; i < 8; i++) begin
            mosi_a = mo[i];
            #10;
            mi[i] = miso_a;
            sclk_a = 1'b1;
            #10;
            sclk_a = 1'b0;
        end
    endtask

    task automatic bits_a(input int n, input logic [7:0] mo);
        for (int i = 0; i < n; i++) begin
            mosi_a = mo[i];
            #10;
            sclk_a = 1'b1;
            #10;
            sclk_a = 1'b0;
        end
    endtask

    // Mode 3, MSB first, 16 bits. Master samples MISO just before the rising edge.
    task automatic word_b(input logic [15:0] tx, input logic [15:0] mo, output logic [15:0] mi);
        tx_b = tx;
        exp_q_b.push_back(mo);
        for (int i = 15; i >= 0; i--) begin
            sclk_b = 1'b0;
            mosi_b = mo[i];
            #10;
            mi[i] = miso_b;
            sclk_b = 1'b1;
            #10;
        end
    endtask

    initial begin
        reset = 1'b0; cs_a = 1'b1; sclk_a = 1'b0; mosi_a = 1'b0; tx_a = 8'h00;
        cs_b = 1'b1; sclk_b = 1'b1; mosi_b = 1'b0; tx_b = 16'h0000;
        #5 reset = 1'b1;
        #10;
        check("reset_miso_a_z", 32'(miso_a), 32'h1);
        check("reset_rx_a", 32'(rx_a), 32'h0);
        check("reset_tog_a", 32'(tog_a), 32'h0);
        check("reset_rx_b", 32'(rx_b), 32'h0);
        check("reset_tog_b", 32'(tog_b), 32'h0);
        #10 reset = 1'b0;
        #10;

        // Defaults: tx A5, receive 3C
        cs_a = 1'b0; #10;
        word_a(8'hA5, 8'h3C, m8);
        #10 cs_a = 1'b1; #10;
        check("basic_miso", 32'(m8), 32'hA5);
        check("basic_tog", 32'(tog_a), 32'h1);
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        check("basic_no_ferr", 32'(ferr_a), 32'h0);
`endif

        // Mode 3, MSB first, 16-bit
        cs_b = 1'b0; #10;
        word_b(16'hBEEF, 16'h1234, m16);
        #10 cs_b = 1'b1; #10;
        check("mode3_miso", 32'(m16), 32'hBEEF);
        check("mode3_tog", 32'(tog_b), 32'h1);

        // Three back-to-back words in one frame
        cs_a = 1'b0; #10;
        word_a(8'h11, 8'hC1, m8);
        check("burst_miso0", 32'(m8), 32'h11);
        word_a(8'h22, 8'hC2, m8);
        check("burst_miso1", 32'(m8), 32'h22);
        word_a(8'h33, 8'hC3, m8);
        check("burst_miso2", 32'(m8), 32'h33);
        #10 cs_a = 1'b1; #10;
        check("burst_tog_cnt", 32'(tog_cnt_a), 32'd4);
        check("burst_rx_last", 32'(rx_a), 32'hC3);
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        check("burst_no_ferr", 32'(ferr_a), 32'h0);
`endif

        // Abort after 5 bits, then a full word
        cs_a = 1'b0; #10;
        bits_a(5, 8'hFF);
        #10 cs_a = 1'b1; #10;
        check("abort_rx_kept", 32'(rx_a), 32'hC3);
        check("abort_tog_kept", 32'(tog_a), 32'h0);
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        check("abort_ferr", 32'(ferr_a), 32'h1);
`endif
        cs_a = 1'b0; #10;
        word_a(8'h00, 8'h5A, m8);
        #10 cs_a = 1'b1; #10;
        check("after_abort_rx", 32'(rx_a), 32'h5A);
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        check("ferr_sticky", 32'(ferr_a), 32'h1);
`endif

        // Reset after 3 bits with CS still low
        tx_a = 8'h5A;
        cs_a = 1'b0; #10;
        bits_a(3, 8'hFF);
        #5 reset = 1'b1;
        #5;
        check("midreset_miso_z", 32'(miso_a), 32'h1);
        check("midreset_rx", 32'(rx_a), 32'h0);
        check("midreset_tog", 32'(tog_a), 32'h0);
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
        check("midreset_ferr", 32'(ferr_a), 32'h0);
`endif
        #10 reset = 1'b0;
        #10;
        word_a(8'h5A, 8'h96, m8);
        check("postreset_miso", 32'(m8), 32'h5A);
        #10 cs_a = 1'b1; #10;
        check("postreset_tog", 32'(tog_a), 32'h1);

        // SCLK activity with CS high is ignored
        for (int i = 0; i < 8; i++) begin
            mosi_a = i[0];
            #10 sclk_a = 1'b1;
            #10 sclk_a = 1'b0;
        end
        #5;
        check("idle_miso_z", 32'(miso_a), 32'h1);
        check("idle_rx", 32'(rx_a), 32'h96);
        check("idle_tog", 32'(tog_a), 32'h1);
        check("total_tog_a", 32'(tog_cnt_a), 32'd6);
        check("total_tog_b", 32'(tog_cnt_b), 32'd1);
        check("queue_a_empty", 32'(exp_q_a.size()), 32'd0);
        check("queue_b_empty", 32'(exp_q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
